// File: rtl/gpr_file_pkg.sv
// Shared core definitions for the general-purpose register file.
package gpr_file_pkg;

    // Default geometry of the integer register file
    localparam int GPR_DATA_WIDTH = 32;
    localparam int GPR_REG_WIDTH  = 5;
    localparam int GPR_CNT_WIDTH  = 32;

    typedef logic [GPR_REG_WIDTH-1:0]  reg_addr_t;
    typedef logic [GPR_DATA_WIDTH-1:0] reg_data_t;

    // Address of the hard-wired zero register x0
    localparam reg_addr_t REG_ZERO = '0;

    // True when a write with these attributes actually updates a stored register
    function automatic logic is_commit(input logic wr_enable, input logic is_x0);
        is_commit = wr_enable & ~is_x0;
    endfunction

endpackage : gpr_file_pkg

// File: rtl/gpr_file_read_port.sv
// One combinational read port: x0 forcing, write-first bypass, storage mux.
module gpr_read_port
    import gpr_file_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int REG_WIDTH  = GPR_REG_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] storage [2**REG_WIDTH],
    input  logic [REG_WIDTH-1:0]  rd_addr,
    input  logic                  wr_enable,
    input  logic [REG_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic rd_is_x0_s;
    logic wr_is_x0_s;
    logic bypass_s;

    assign rd_is_x0_s = (rd_addr == REG_WIDTH'(REG_ZERO));
    assign wr_is_x0_s = (wr_addr == REG_WIDTH'(REG_ZERO));
    assign bypass_s   = is_commit(wr_enable, wr_is_x0_s) && (wr_addr == rd_addr);

    // Select zero for x0, in-flight write data on an address match, else stored value
    always_comb begin
        rd_data = {DATA_WIDTH{1'b0}};
        if (rd_is_x0_s) begin
            rd_data = {DATA_WIDTH{1'b0}};
        end else if (bypass_s) begin
            rd_data = wr_data;
        end else begin
            rd_data = storage[rd_addr];
        end
    end

endmodule : gpr_read_port

// File: rtl/gpr_file.sv
// General-purpose register file: one write port from MEM/WB, two bypassed
// operand read ports for ID, a registered debug read port and a write counter.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int REG_WIDTH  = GPR_REG_WIDTH,
    parameter int CNT_WIDTH  = GPR_CNT_WIDTH
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [REG_WIDTH-1:0]  i_WrAddr,
    input  logic                  i_WrEnable,
    input  logic [DATA_WIDTH-1:0] i_WrData,
    input  logic [REG_WIDTH-1:0]  i_RdAddrA,
    output logic [DATA_WIDTH-1:0] o_RdDataA,
    input  logic [REG_WIDTH-1:0]  i_RdAddrB,
    output logic [DATA_WIDTH-1:0] o_RdDataB,
    input  logic [REG_WIDTH-1:0]  i_DbgRdAddr,
    input  logic                  i_DbgRdReq,
    output logic [DATA_WIDTH-1:0] o_DbgRdData,
    output logic                  o_DbgRdValid,
    output logic [CNT_WIDTH-1:0]  o_WrCount
);

    localparam int NUM_REGS = 2**REG_WIDTH;

    // x1..xN-1 are flops; x0 exists only as a constant in the read view
    logic [DATA_WIDTH-1:0] regs_r    [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] storage_s [NUM_REGS];
    logic [DATA_WIDTH-1:0] dbg_mux_s;
    logic [DATA_WIDTH-1:0] dbg_rd_data_r;
    logic                  dbg_rd_valid_r;
    logic [CNT_WIDTH-1:0]  wr_count_r;
    logic                  wr_commit_s;

    assign wr_commit_s = is_commit(i_WrEnable, (i_WrAddr == REG_WIDTH'(REG_ZERO)));

    // Build the full read view with x0 pinned to zero
    always_comb begin
        storage_s[0] = {DATA_WIDTH{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            storage_s[i] = regs_r[i];
        end
    end

    // Register storage: reset clears everything, a committed write updates one entry
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_commit_s && (i_WrAddr == REG_WIDTH'(i))) begin
                    regs_r[i] <= i_WrData;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Retired-write counter, wraps naturally at its width
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_count_r <= {CNT_WIDTH{1'b0}};
        end else if (wr_commit_s) begin
            wr_count_r <= wr_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // Debug read: capture the bypassed value on request; data holds otherwise
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            dbg_rd_data_r  <= {DATA_WIDTH{1'b0}};
            dbg_rd_valid_r <= 1'b0;
        end else if (i_DbgRdReq) begin
            dbg_rd_data_r  <= dbg_mux_s;
            dbg_rd_valid_r <= 1'b1;
        end else begin
            dbg_rd_data_r  <= dbg_rd_data_r;
            dbg_rd_valid_r <= 1'b0;
        end
    end

    gpr_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH)
    ) u_port_a (
        .storage   (storage_s),
        .rd_addr   (i_RdAddrA),
        .wr_enable (i_WrEnable),
        .wr_addr   (i_WrAddr),
        .wr_data   (i_WrData),
        .rd_data   (o_RdDataA)
    );

    gpr_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH)
    ) u_port_b (
        .storage   (storage_s),
        .rd_addr   (i_RdAddrB),
        .wr_enable (i_WrEnable),
        .wr_addr   (i_WrAddr),
        .wr_data   (i_WrData),
        .rd_data   (o_RdDataB)
    );

    gpr_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH)
    ) u_port_dbg (
        .storage   (storage_s),
        .rd_addr   (i_DbgRdAddr),
        .wr_enable (i_WrEnable),
        .wr_addr   (i_WrAddr),
        .wr_data   (i_WrData),
        .rd_data   (dbg_mux_s)
    );

    assign o_DbgRdData  = dbg_rd_data_r;
    assign o_DbgRdValid = dbg_rd_valid_r;
    assign o_WrCount    = wr_count_r;

endmodule : gpr_file

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file (4-bit counter so wrap is reachable).
module tb_gpr_file;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          i_Clock;
    logic          i_Reset;
    logic [RW-1:0] i_WrAddr;
    logic          i_WrEnable;
    logic [DW-1:0] i_WrData;
    logic [RW-1:0] i_RdAddrA;
    logic [DW-1:0] o_RdDataA;
    logic [RW-1:0] i_RdAddrB;
    logic [DW-1:0] o_RdDataB;
    logic [RW-1:0] i_DbgRdAddr;
    logic          i_DbgRdReq;
    logic [DW-1:0] o_DbgRdData;
    logic          o_DbgRdValid;
    logic [CW-1:0] o_WrCount;

    gpr_file #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_WrAddr     (i_WrAddr),
        .i_WrEnable   (i_WrEnable),
        .i_WrData     (i_WrData),
        .i_RdAddrA    (i_RdAddrA),
        .o_RdDataA    (o_RdDataA),
        .i_RdAddrB    (i_RdAddrB),
        .o_RdDataB    (o_RdDataB),
        .i_DbgRdAddr  (i_DbgRdAddr),
        .i_DbgRdReq   (i_DbgRdReq),
        .o_DbgRdData  (o_DbgRdData),
        .o_DbgRdValid (o_DbgRdValid),
        .o_WrCount    (o_WrCount)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Scoreboard entries: sel 0=A 1=B 2=count 3=dbg data 4=dbg valid
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        comb_q[$];
    logic [31:0] dbg_q[$];
    event        chk_ev;
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       sample = o_RdDataA;
            1:       sample = o_RdDataB;
            2:       sample = {28'd0, o_WrCount};
            3:       sample = o_DbgRdData;
            4:       sample = {31'd0, o_DbgRdValid};
            default: sample = 32'hxxxxxxxx;
        endcase
    endfunction

    // Monitor for immediate observations requested by the stimulus
    initial begin
        chk_t c;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            while (comb_q.size() > 0) begin
                c   = comb_q.pop_front();
                act = sample(c.sel);
                n_cmp++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h at %0t", c.name, act, c.exp, $time);
                end
            end
        end
    end

    // Monitor for the debug port: every valid pulse consumes one expected value
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge i_Clock);
            if (o_DbgRdValid === 1'b1) begin
                n_cmp++;
                if (dbg_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dbg_unexpected: got valid with data %08h, expected no response", o_DbgRdData);
                end else begin
                    e = dbg_q.pop_front();
                    if (o_DbgRdData !== e) begin
                        n_fail++;
                        $display("FAIL dbg_data: got %08h expected %08h at %0t", o_DbgRdData, e, $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        comb_q.push_back(c);
        -> chk_ev;
        wait (comb_q.size() == 0);
    endtask

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic wr(input logic [RW-1:0] a, input logic en, input logic [31:0] d);
        i_WrAddr   = a;
        i_WrEnable = en;
        i_WrData   = d;
    endtask

    initial begin
        i_Reset     = 1'b1;
        i_WrAddr    = '0;
        i_WrEnable  = 1'b0;
        i_WrData    = '0;
        i_RdAddrA   = 5'd5;
        i_RdAddrB   = 5'd31;
        i_DbgRdAddr = '0;
        i_DbgRdReq  = 1'b0;
        repeat (2) @(posedge i_Clock);
        #2 i_Reset = 1'b0;

        // Put some state in, then reset asynchronously between edges
        wr(5'd5, 1'b1, 32'h0000_0011);
        i_DbgRdAddr = 5'd5;
        i_DbgRdReq  = 1'b1;
        dbg_q.push_back(32'h0000_0011);
        step();
        wr(5'd5, 1'b0, 32'h0);
        i_DbgRdReq = 1'b0;
        chk("pre_rst_a5", 0, 32'h0000_0011);
        chk("pre_rst_cnt", 2, 32'd1);
        @(negedge i_Clock);
        #2 i_Reset = 1'b1;
        #1;
        chk("rst_a5", 0, 32'h0);
        chk("rst_b31", 1, 32'h0);
        chk("rst_cnt", 2, 32'd0);
        chk("rst_dbg_data", 3, 32'h0);
        chk("rst_dbg_valid", 4, 32'd0);
        @(posedge i_Clock);
        #2 i_Reset = 1'b0;

        // Basic write then read from storage
        wr(5'd3, 1'b1, 32'hDEAD_BEEF);
        i_RdAddrA = 5'd3;
        i_RdAddrB = 5'd4;
        #1;
        chk("wr3_b4_empty", 1, 32'h0);
        step();
        wr(5'd3, 1'b0, 32'h0);
        #1;
        chk("rd_a3", 0, 32'hDEAD_BEEF);
        chk("cnt_1", 2, 32'd1);

        // Bypass on both ports, then the same vector without enable
        wr(5'd7, 1'b1, 32'h1234_5678);
        i_RdAddrA = 5'd7;
        i_RdAddrB = 5'd7;
        #1;
        chk("byp_a7", 0, 32'h1234_5678);
        chk("byp_b7", 1, 32'h1234_5678);
        i_WrEnable = 1'b0;
        #1;
        chk("nobyp_a7", 0, 32'h0);
        chk("nobyp_b7", 1, 32'h0);
        i_WrEnable = 1'b1;
        step();
        wr(5'd7, 1'b0, 32'hCAFE_F00D);
        #1;
        chk("old_a7", 0, 32'h1234_5678);
        chk("cnt_2", 2, 32'd2);

        // x0 guard
        wr(5'd0, 1'b1, 32'hFFFF_FFFF);
        i_RdAddrA = 5'd0;
        #1;
        chk("x0_same", 0, 32'h0);
        chk("x0_b7", 1, 32'h1234_5678);
        step();
        wr(5'd0, 1'b0, 32'h0);
        #1;
        chk("x0_next", 0, 32'h0);
        chk("x0_cnt", 2, 32'd2);

        // Debug read write-first, then valid drops while data holds
        wr(5'd10, 1'b1, 32'hA5A5_A5A5);
        i_DbgRdAddr = 5'd10;
        i_DbgRdReq  = 1'b1;
        dbg_q.push_back(32'hA5A5_A5A5);
        step();
        wr(5'd10, 1'b0, 32'h0);
        i_DbgRdReq = 1'b0;
        chk("dbg_valid_1", 4, 32'd1);
        chk("cnt_3", 2, 32'd3);
        step();
        chk("dbg_valid_0", 4, 32'd0);
        chk("dbg_hold", 3, 32'hA5A5_A5A5);

        // Back-to-back debug reads
        i_DbgRdReq  = 1'b1;
        i_DbgRdAddr = 5'd3;
        dbg_q.push_back(32'hDEAD_BEEF);
        step();
        i_DbgRdAddr = 5'd10;
        dbg_q.push_back(32'hA5A5_A5A5);
        step();
        i_DbgRdAddr = 5'd0;
        dbg_q.push_back(32'h0);
        step();
        i_DbgRdReq = 1'b0;
        step();
        chk("b2b_valid_0", 4, 32'd0);

        // Consecutive writes to one register: last wins
        wr(5'd12, 1'b1, 32'h0000_0001);
        step();
        wr(5'd12, 1'b1, 32'h0000_0002);
        step();
        wr(5'd12, 1'b0, 32'h0);
        i_RdAddrA = 5'd12;
        #1;
        chk("last_wins", 0, 32'h0000_0002);
        chk("cnt_5", 2, 32'd5);

        // Eleven more writes: 5 + 11 = 16 wraps the 4-bit counter to 0
        for (int i = 1; i <= 11; i++) begin
            wr(RW'(i), 1'b1, 32'(i));
            step();
        end
        wr(5'd0, 1'b0, 32'h0);
        #1;
        chk("cnt_wrap", 2, 32'd0);
        i_RdAddrA = 5'd9;
        #1;
        chk("x9_before", 0, 32'd9);

        // Reset pulse during a write to x9: the write is lost
        wr(5'd9, 1'b1, 32'h9999_9999);
        #3 i_Reset = 1'b1;
        @(posedge i_Clock);
        #2 i_Reset = 1'b0;
        wr(5'd9, 1'b0, 32'h0);
        #1;
        chk("x9_lost", 0, 32'h0);
        chk("rst2_cnt", 2, 32'd0);

        // First edge after reset accepts a write
        wr(5'd9, 1'b1, 32'h0000_0077);
        step();
        wr(5'd9, 1'b0, 32'h0);
        #1;
        chk("x9_after", 0, 32'h0000_0077);
        chk("cnt_after", 2, 32'd1);

        step();
        n_cmp++;
        if (dbg_q.size() != 0) begin
            n_fail++;
            $display("FAIL dbg_missing: got %0d outstanding responses, expected 0", dbg_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_gpr_file
